// File: rtl/neuron_sequencer.sv
// Streaming single-neuron MAC: accumulates bias + sum(x*w) over a vector, then shifts and saturates.
// Optional ReLU on the output when NEURON_SEQUENCER_RELU_EN is defined.
module neuron_sequencer #(
   parameter int N     = 4,
   parameter int SHIFT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_wr_en,
   input  logic [4:0]        w_addr,
   input  logic signed [7:0] w_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] in_x,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [7:0] out_data,
   output logic              count_err
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

   state_t                   state, state_nxt;
   logic [IW-1:0]            idx;
   logic signed [7:0]        w [N];
   logic signed [7:0]        bias;
   logic signed [20:0]       acc, acc_nxt;
   logic signed [15:0]       prod;
   logic                     accept, last_beat, idx_end;

   function automatic logic signed [7:0] sat8(input logic signed [20:0] v);
      if (v > 21'sd127)
         return 8'sd127;
      else if (v < -21'sd128)
         return -8'sd128;
      else
         return v[7:0];
   endfunction

   function automatic logic signed [7:0] shape(input logic signed [20:0] a);
      logic signed [20:0] sh;
      logic signed [7:0]  s;
      sh = a >>> SHIFT;
      s  = sat8(sh);
`ifdef NEURON_SEQUENCER_RELU_EN
      if (s < 0)
         s = '0;
`endif
      return s;
   endfunction

   // Weight read sees the registered value, so a same-cycle write is not yet visible
   assign prod = in_x * w[idx];

   always_comb begin
      state_nxt = state;
      in_ready  = (state != OUT);
      accept    = in_valid && in_ready;
      idx_end   = (idx == IW'(N - 1));
      last_beat = in_last || idx_end;
      count_err = accept && last_beat && (in_last != idx_end) && !rst;
      acc_nxt   = (state == IDLE) ? ({{13{bias[7]}}, bias} + {{5{prod[15]}}, prod})
                                  : (acc + {{5{prod[15]}}, prod});
      case (state)
         IDLE:    if (accept) state_nxt = last_beat ? OUT : ACCUM;
         ACCUM:   if (accept && last_beat) state_nxt = OUT;
         OUT:     if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         bias      <= '0;
         for (int i = 0; i < N; i++)
            w[i] <= '0;
      end else begin
         if (w_wr_en) begin
            if (w_addr == 5'd16)
               bias <= w_data;
            else if (w_addr < 5'(N))
               w[w_addr[IW-1:0]] <= w_data;
         end
         if (accept) begin
            acc <= acc_nxt;
            idx <= last_beat ? '0 : idx + IW'(1);
            if (last_beat) begin
               out_valid <= 1'b1;
               out_data  <= shape(acc_nxt);
            end
         end
         if (out_valid && out_ready)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: directed vector table, hand sequences, random vs. reference model.
module tb_neuron_sequencer;

   localparam int N     = 4;
   localparam int SHIFT = 4;

   logic              clk = 0;
   logic              rst = 1;
   logic              w_wr_en = 0;
   logic [4:0]        w_addr = '0;
   logic signed [7:0] w_data = '0;
   logic              in_valid = 0;
   logic              in_ready;
   logic signed [7:0] in_x = '0;
   logic              in_last = 0;
   logic              out_valid;
   logic              out_ready = 0;
   logic signed [7:0] out_data;
   logic              count_err;

   int nchk = 0;
   int nerr = 0;
   int mdl_w [N];
   int mdl_b;

   typedef struct packed {
      logic [3:0][7:0] w;
      logic [7:0]      b;
      logic [3:0][7:0] x;
      logic [2:0]      nb;
      logic            lst;
      logic [7:0]      exp;
      logic            err;
   } vec_t;

   vec_t tbl [8];

   neuron_sequencer #(.N(N), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count_err(count_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int relu_x(input int v);
`ifdef NEURON_SEQUENCER_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // Reference: bias + dot product over the beats actually sent, floor-shift, clamp, optional ReLU
   function automatic int model(input int nb, input logic [3:0][7:0] xs);
      int s;
      s = mdl_b;
      for (int i = 0; i < nb; i++)
         s += $signed(xs[i]) * mdl_w[i];
      s = s >>> SHIFT;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return relu_x(s);
   endfunction

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      w_wr_en = 1; w_addr = a; w_data = d;
      @(negedge clk);
      w_wr_en = 0;
      if (a == 5'd16) mdl_b = $signed(d);
      else if (a < 5'(N)) mdl_w[a] = $signed(d);
   endtask

   task automatic run_vec(input string nm, input logic [3:0][7:0] xs, input int nb,
                          input bit lst, input int exp, input bit err, input int hold);
      for (int i = 0; i < nb; i++) begin
         in_valid = 1; in_x = xs[i]; in_last = lst && (i == nb - 1);
         #1;
         chk({nm, "_rdy"}, int'(in_ready), 1);
         chk({nm, "_cerr"}, int'(count_err), (i == nb - 1) ? int'(err) : 0);
         @(negedge clk);
         w_wr_en = 0;
      end
      in_valid = 0; in_last = 0;
      for (int k = 0; k < hold; k++) begin
         in_valid = 1; in_x = 8'h55;
         #1;
         chk({nm, "_hold_vld"}, int'(out_valid), 1);
         chk({nm, "_hold_data"}, int'(out_data), exp);
         chk({nm, "_hold_rdy"}, int'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1;
      #1;
      chk({nm, "_vld"}, int'(out_valid), 1);
      chk({nm, "_data"}, int'(out_data), exp);
      @(negedge clk);
      out_ready = 0; in_valid = 0;
      #1;
      chk({nm, "_done_vld"}, int'(out_valid), 0);
      chk({nm, "_done_rdy"}, int'(in_ready), 1);
   endtask

   initial begin
      vec_t t;
      logic [3:0][7:0] xs;
      int nb, expv;
      bit lst, err;

      for (int i = 0; i < N; i++) mdl_w[i] = 0;
      mdl_b = 0;

      //           w (w3..w0)                       b      x (x3..x0)                      nb    lst   exp     err
      tbl[0] = '{{8'd4, 8'd3, 8'd2, 8'd1},         8'd16, {4{8'd16}},                     3'd4, 1'b1, 8'd11,  1'b0};
      tbl[1] = '{{4{8'd127}},                      8'd0,  {4{8'd127}},                    3'd4, 1'b1, 8'd127, 1'b0};
      tbl[2] = '{{4{8'h80}},                       8'd0,  {4{8'd127}},                    3'd4, 1'b1, 8'h80,  1'b0};
      tbl[3] = '{{8'd4, 8'd3, 8'd2, 8'd1},         8'd16, {8'd0, 8'd0, 8'd16, 8'd16},     3'd2, 1'b1, 8'd4,   1'b1};
      tbl[4] = '{{8'd4, 8'd3, 8'd2, 8'd1},         8'd16, {4{8'd16}},                     3'd4, 1'b0, 8'd11,  1'b1};
      tbl[5] = '{{4{8'hFF}},                       8'd0,  {4{8'd16}},                     3'd4, 1'b1, 8'hFC,  1'b0};
      tbl[6] = '{{4{8'd0}},                        8'h80, {4{8'd5}},                      3'd1, 1'b1, 8'hF8,  1'b1};
      tbl[7] = '{{4{8'd0}},                        8'hFF, {4{8'd9}},                      3'd4, 1'b1, 8'hFF,  1'b0};

      @(negedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_count_err", int'(count_err), 0);
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         t = tbl[v];
         for (int i = 0; i < N; i++) wr(5'(i), t.w[i]);
         wr(5'd16, t.b);
         run_vec($sformatf("tbl%0d", v), t.x, int'(t.nb), t.lst,
                 relu_x(int'($signed(t.exp))), t.err, 0);
      end

      // Output back-pressure, then next vector right after the handshake
      for (int i = 0; i < N; i++) wr(5'(i), 8'(i + 1));
      wr(5'd16, 8'd16);
      run_vec("hold", {4{8'd16}}, 4, 1, 11, 0, 3);
      run_vec("after_hold", {4{8'd16}}, 4, 1, 11, 0, 0);

      // Write to w0 concurrent with beat 0: beat 0 uses the old weight, next vector the new one
      w_wr_en = 1; w_addr = 5'd0; w_data = 8'd5;
      run_vec("wr_same_cycle", {4{8'd16}}, 4, 1, 11, 0, 0);
      mdl_w[0] = 5;
      run_vec("wr_next_vec", {4{8'd16}}, 4, 1, 15, 0, 0);

      // Reset mid-vector discards the partial result and clears weights/bias
      in_valid = 1; in_x = 8'd16; in_last = 0;
      @(negedge clk);
      @(negedge clk);
      in_valid = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      for (int i = 0; i < N; i++) mdl_w[i] = 0;
      mdl_b = 0;
      run_vec("midrst_fresh", {8'd7, 8'd100, 8'h90, 8'd16}, 4, 1, 0, 0, 0);

      // Randomized vectors against the reference model
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) != 0) wr(5'(i), 8'($urandom));
         if ($urandom_range(0, 1) != 0) wr(5'd16, 8'($urandom));
         if ($urandom_range(0, 3) == 0) wr(5'($urandom_range(17, 31)), 8'($urandom));
         if ($urandom_range(0, 3) == 0) wr(5'($urandom_range(4, 15)), 8'($urandom));
         nb  = $urandom_range(1, N);
         lst = (nb < N) ? 1'b1 : 1'($urandom_range(0, 1));
         err = !(nb == N && lst);
         for (int i = 0; i < N; i++) xs[i] = 8'($urandom);
         expv = model(nb, xs);
         run_vec($sformatf("rnd%0d", r), xs, nb, lst, expv, err, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
